stopwatch_ctrl: RTL and testbench

STOPWATCH_CTRL -- requirements
Module: stopwatch_ctrl

---
 rtl/stopwatch_ctrl.sv | 144 ++++++++++++++
 tb/tb_stopwatch_ctrl.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control: per-button sync/debounce/press-pulse lanes feeding a
// CLEAR/RUN/PAUSE/DONE FSM that steers an external 4-digit BCD counter.

module stopwatch_btn #(
  parameter int DB_CYCLES = 16
) (
  input  logic c_clk,
  input  logic C_clr,
  input  logic btn,
  output logic press
);
  logic [1:0]  sync_q;
  logic        db_q;
  logic        db_d1;
  logic [15:0] db_cnt;

  always_ff @(posedge c_clk or posedge C_clr) begin
    if (C_clr) begin
      sync_q <= '0;
      db_q   <= 1'b0;
      db_d1  <= 1'b0;
      db_cnt <= '0;
      press  <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], btn};
      db_d1  <= db_q;
      press  <= db_q & ~db_d1;
      if (sync_q[1] == db_q) begin
        db_cnt <= '0;
      end else if (db_cnt == 16'(DB_CYCLES - 1)) begin
        // DB_CYCLES-th consecutive mismatch: accept the new level
        db_cnt <= '0;
        db_q   <= ~db_q;
      end else begin
        db_cnt <= db_cnt + 16'd1;
      end
    end
  end
endmodule

module stopwatch_ctrl #(
  parameter int DB_CYCLES = 16
) (
  input  logic        c_clk,
  input  logic        C_clr,
  input  logic        btn_pp,
  input  logic        btn_rst,
  input  logic [1:0]  sel,
  input  logic [7:0]  load,
  input  logic        tick_in,
  input  logic [15:0] cnt_val,
  output logic        clr_out,
  output logic        cnt_en,
  output logic [15:0] preset,
  output logic        dir,
  output logic        done,
  output logic [1:0]  state_out
);
  localparam int NUM_LANES = 2;
  localparam int L_PP      = 0;
  localparam int L_RST     = 1;

  typedef enum logic [1:0] {
    CLEAR = 2'b00,
    RUN   = 2'b01,
    PAUSE = 2'b10,
    DONE  = 2'b11
  } state_t;

  state_t               state_q, state_d;
  logic [NUM_LANES-1:0] btn_raw;
  logic [NUM_LANES-1:0] press;
  logic                 dir_q;
  logic [15:0]          preset_q, preset_d;
  logic                 terminal;

  assign btn_raw = {btn_rst, btn_pp};

  generate
    for (genvar g = 0; g < NUM_LANES; g++) begin : g_btn
      stopwatch_btn #(.DB_CYCLES(DB_CYCLES)) u_btn (
        .c_clk (c_clk),
        .C_clr (C_clr),
        .btn   (btn_raw[g]),
        .press (press[g])
      );
    end
  endgenerate

  function automatic logic [3:0] clamp9(input logic [3:0] d);
    return (d > 4'd9) ? 4'd9 : d;
  endfunction

  always_comb begin
    preset_d = 16'h0000;
    case (sel)
      2'd0:    preset_d = 16'h0000;
      2'd2:    preset_d = 16'h9999;
      default: preset_d = {clamp9(load[7:4]), clamp9(load[3:0]), 8'h00};
    endcase
  end

  // Mode and preset only track the inputs while cleared; frozen otherwise
  always_ff @(posedge c_clk or posedge C_clr) begin
    if (C_clr) begin
      dir_q    <= 1'b0;
      preset_q <= 16'h0000;
    end else if (state_q == CLEAR) begin
      dir_q    <= sel[1];
      preset_q <= preset_d;
    end
  end

  assign terminal = dir_q ? (cnt_val == 16'h0000) : (cnt_val == 16'h9999);

  always_ff @(posedge c_clk or posedge C_clr) begin
    if (C_clr) state_q <= CLEAR;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (press[L_RST]) begin
      state_d = CLEAR;
    end else begin
      case (state_q)
        CLEAR: if (press[L_PP]) state_d = RUN;
        RUN: begin
          if (press[L_PP])  state_d = PAUSE;
          else if (terminal) state_d = DONE;
        end
        PAUSE: if (press[L_PP]) state_d = RUN;
        default: state_d = state_q;
      endcase
    end
  end

  assign clr_out   = (state_q == CLEAR);
  assign done      = (state_q == DONE);
  assign cnt_en    = (state_q == RUN) & tick_in & ~terminal;
  assign preset    = preset_q;
  assign dir       = dir_q;
  assign state_out = state_q;
endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Randomized bench for stopwatch_ctrl against a sample-history debounce model
// and a state-table FSM model, plus directed corner scenarios.

module tb_stopwatch_ctrl;
  localparam int DB = 5;

  logic        c_clk = 1'b0;
  logic        C_clr, btn_pp, btn_rst, tick_in;
  logic [1:0]  sel;
  logic [7:0]  load;
  logic [15:0] cnt_val;
  logic        clr_out, cnt_en, dir, done;
  logic [15:0] preset;
  logic [1:0]  state_out;

  int n_tests = 0;
  int n_fail  = 0;

  stopwatch_ctrl #(.DB_CYCLES(DB)) dut (
    .c_clk     (c_clk),
    .C_clr     (C_clr),
    .btn_pp    (btn_pp),
    .btn_rst   (btn_rst),
    .sel       (sel),
    .load      (load),
    .tick_in   (tick_in),
    .cnt_val   (cnt_val),
    .clr_out   (clr_out),
    .cnt_en    (cnt_en),
    .preset    (preset),
    .dir       (dir),
    .done      (done),
    .state_out (state_out)
  );

  always #5 c_clk = ~c_clk;

  // Reference model state: 0 CLEAR, 1 RUN, 2 PAUSE, 3 DONE
  int          m_state;
  logic [15:0] m_preset;
  logic        m_dir;
  logic        m_deb[2];
  logic        m_rose[2];
  logic        m_ev[2];
  logic [1:0]  hist[$];   // raw {rst,pp} sampled at every edge

  function automatic logic [15:0] bcd4(input int v);
    return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
  endfunction

  function automatic logic m_term(input logic [15:0] v);
    return m_dir ? (v == bcd4(0)) : (v == bcd4(9999));
  endfunction

  function automatic logic m_cnt_en();
    return (m_state == 1) && tick_in && !m_term(cnt_val);
  endfunction

  task automatic model_reset();
    hist.delete();
    for (int i = 0; i < DB + 2; i++) hist.push_back(2'b00);
    for (int b = 0; b < 2; b++) begin
      m_deb[b] = 1'b0; m_rose[b] = 1'b0; m_ev[b] = 1'b0;
    end
    m_state = 0; m_preset = 16'h0000; m_dir = 1'b0;
  endtask

  task automatic model_edge();
    int nxt, hi, lo, L;
    logic tog;
    nxt = m_state;
    if (m_ev[1]) nxt = 0;
    else case (m_state)
      0: if (m_ev[0]) nxt = 1;
      1: if (m_ev[0]) nxt = 2; else if (m_term(cnt_val)) nxt = 3;
      2: if (m_ev[0]) nxt = 1;
      default: nxt = m_state;
    endcase
    if (m_state == 0) begin
      hi = (load[7:4] > 9) ? 9 : int'(load[7:4]);
      lo = (load[3:0] > 9) ? 9 : int'(load[3:0]);
      m_dir = sel[1];
      m_preset = (sel == 2'd0) ? bcd4(0) : (sel == 2'd2) ? bcd4(9999) : bcd4(1000 * hi + 100 * lo);
    end
    m_state = nxt;
    // debounced level flips once the last DB synchronized samples all disagree
    hist.push_back({btn_rst, btn_pp});
    L = hist.size();
    for (int b = 0; b < 2; b++) begin
      m_ev[b] = m_rose[b];
      tog = 1'b1;
      for (int i = L - 2 - DB; i <= L - 3; i++) if (hist[i][b] == m_deb[b]) tog = 1'b0;
      m_rose[b] = tog && !m_deb[b];
      if (tog) m_deb[b] = ~m_deb[b];
    end
    if (L > DB + 8) void'(hist.pop_front());
  endtask

  task automatic cyc();
    @(posedge c_clk);
    model_edge();
    #1;
  endtask

  // Stimulus only: one clean press of the chosen buttons, then full settle
  task automatic press(input logic pp, input logic rst);
    btn_pp = pp; btn_rst = rst;
    repeat (DB + 1) cyc();
    btn_pp = 1'b0; btn_rst = 1'b0;
    repeat (2 * DB + 4) cyc();
  endtask

  task automatic test_reset();
    C_clr = 1'b1; btn_pp = 0; btn_rst = 0; sel = 0; load = 0; tick_in = 1; cnt_val = 16'h1234;
    model_reset();
    #3;
    n_tests++;
    if ({state_out, clr_out, cnt_en, done, dir, preset} !== {2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000}) begin
      n_fail++;
      $display("FAIL reset_outputs: got st=%0d clr=%b en=%b done=%b dir=%b pre=%h, want 0 1 0 0 0 0000",
               state_out, clr_out, cnt_en, done, dir, preset);
    end
    @(posedge c_clk); @(posedge c_clk); #1;
    C_clr = 1'b0;
    tick_in = 1'b0;
  endtask

  task automatic test_press_latency();
    sel = 2'd0; load = 8'($urandom); cnt_val = 16'h1234; btn_pp = 1'b1;
    for (int k = 1; k <= DB + 5; k++) begin
      cyc();
      n_tests++;
      if (state_out !== ((k >= DB + 4) ? 2'd1 : 2'd0)) begin
        n_fail++;
        $display("FAIL press_latency edge %0d: got state %0d want %0d", k, state_out, (k >= DB + 4) ? 1 : 0);
      end
    end
    btn_pp = 1'b0;
    for (int k = 0; k < 2 * DB + 6; k++) begin
      cyc();
      tick_in = 1'($urandom);
      #1;
      n_tests++;
      if ({state_out, cnt_en, clr_out} !== {2'd1, tick_in, 1'b0}) begin
        n_fail++;
        $display("FAIL run_mirror: got st=%0d en=%b clr=%b want 1 %b 0", state_out, cnt_en, clr_out, tick_in);
      end
    end
  endtask

  task automatic test_glitch();
    btn_pp = 1'b1;
    repeat (DB - 1) cyc();
    btn_pp = 1'b0;
    for (int k = 0; k < DB + 6; k++) begin
      cyc();
      n_tests++;
      if (state_out !== 2'd1) begin
        n_fail++;
        $display("FAIL glitch_ignored: got state %0d want 1", state_out);
      end
    end
  endtask

  task automatic test_preset_freeze();
    tick_in = 1'b0;
    press(1'b0, 1'b1);
    sel = 2'd3; load = 8'hA5;
    cyc();
    n_tests++;
    if ({state_out, preset, dir} !== {2'd0, 16'h9500, 1'b1}) begin
      n_fail++;
      $display("FAIL preset_clamp: got st=%0d pre=%h dir=%b want 0 9500 1", state_out, preset, dir);
    end
    press(1'b1, 1'b0);
    sel = 2'd0; load = 8'h37;
    repeat (3) cyc();
    n_tests++;
    if ({state_out, preset, dir} !== {2'd1, 16'h9500, 1'b1}) begin
      n_fail++;
      $display("FAIL preset_frozen: got st=%0d pre=%h dir=%b want 1 9500 1", state_out, preset, dir);
    end
  endtask

  task automatic test_done();
    press(1'b0, 1'b1);
    sel = 2'd0;
    cyc();
    press(1'b1, 1'b0);
    cnt_val = 16'h9999; tick_in = 1'b1;
    #1;
    n_tests++;
    if ({state_out, cnt_en} !== {2'd1, 1'b0}) begin
      n_fail++;
      $display("FAIL terminal_hold: got st=%0d en=%b want 1 0", state_out, cnt_en);
    end
    cyc();
    n_tests++;
    if ({state_out, done} !== {2'd3, 1'b1}) begin
      n_fail++;
      $display("FAIL enter_done: got st=%0d done=%b want 3 1", state_out, done);
    end
    press(1'b1, 1'b0);
    n_tests++;
    if ({state_out, done, cnt_en} !== {2'd3, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL done_ignores_pp: got st=%0d done=%b en=%b want 3 1 0", state_out, done, cnt_en);
    end
  endtask

  task automatic test_simul_rst_pp();
    press(1'b0, 1'b1);
    sel = 2'd0; cnt_val = 16'h1234;
    cyc();
    press(1'b1, 1'b0);
    press(1'b1, 1'b0);
    n_tests++;
    if (state_out !== 2'd2) begin
      n_fail++;
      $display("FAIL reach_pause: got state %0d want 2", state_out);
    end
    press(1'b1, 1'b1);
    n_tests++;
    if ({state_out, clr_out} !== {2'd0, 1'b1}) begin
      n_fail++;
      $display("FAIL rst_priority: got st=%0d clr=%b want 0 1", state_out, clr_out);
    end
  endtask

  task automatic test_preset_terminal();
    sel = 2'd3; load = 8'h00; cnt_val = 16'h0000; tick_in = 1'b1;
    cyc();
    n_tests++;
    if ({preset, dir} !== {16'h0000, 1'b1}) begin
      n_fail++;
      $display("FAIL preset_zero: got pre=%h dir=%b want 0000 1", preset, dir);
    end
    btn_pp = 1'b1;
    repeat (DB + 3) cyc();
    btn_pp = 1'b0;
    cyc();
    n_tests++;
    if ({state_out, cnt_en} !== {2'd1, 1'b0}) begin
      n_fail++;
      $display("FAIL run_entry_terminal: got st=%0d en=%b want 1 0", state_out, cnt_en);
    end
    cyc();
    n_tests++;
    if (state_out !== 2'd3) begin
      n_fail++;
      $display("FAIL immediate_done: got state %0d want 3", state_out);
    end
    repeat (2 * DB) cyc();
    press(1'b0, 1'b1);
    sel = 2'd1; load = 8'h99; cnt_val = 16'h9900;
    cyc();
    press(1'b1, 1'b0);
    repeat (3) cyc();
    n_tests++;
    if ({state_out, preset, dir} !== {2'd1, 16'h9900, 1'b0}) begin
      n_fail++;
      $display("FAIL preset_9900: got st=%0d pre=%h dir=%b want 1 9900 0", state_out, preset, dir);
    end
  endtask

  task automatic test_random();
    int pp_left = 0, rst_left = 0, r;
    for (int k = 0; k < 1500; k++) begin
      cyc();
      if (pp_left == 0) begin
        btn_pp = 1'($urandom_range(0, 2) == 0); pp_left = $urandom_range(1, 2 * DB + 4);
      end
      if (rst_left == 0) begin
        btn_rst = 1'($urandom_range(0, 5) == 0); rst_left = $urandom_range(1, 3 * DB);
      end
      pp_left--; rst_left--;
      sel = 2'($urandom); load = 8'($urandom); tick_in = 1'($urandom);
      r = $urandom_range(0, 5);
      cnt_val = (r == 0) ? 16'h0000 : (r == 1) ? 16'h9999 : (r == 2) ? m_preset : bcd4($urandom_range(1, 9998));
      #1;
      n_tests++;
      if ({state_out, clr_out, done, cnt_en, dir, preset} !==
          {2'(m_state), m_state == 0, m_state == 3, m_cnt_en(), m_dir, m_preset}) begin
        n_fail++;
        $display("FAIL random cyc %0d: got st=%0d clr=%b done=%b en=%b dir=%b pre=%h want st=%0d en=%b dir=%b pre=%h",
                 k, state_out, clr_out, done, cnt_en, dir, preset, m_state, m_cnt_en(), m_dir, m_preset);
      end
    end
    btn_pp = 1'b0; btn_rst = 1'b0;
    repeat (3 * DB) cyc();
  endtask

  task automatic test_clr_midrun();
    press(1'b0, 1'b1);
    sel = 2'd0; cnt_val = 16'h4321; tick_in = 1'b1;
    cyc();
    press(1'b1, 1'b0);
    n_tests++;
    if ({state_out, cnt_en} !== {2'd1, 1'b1}) begin
      n_fail++;
      $display("FAIL pre_clr_run: got st=%0d en=%b want 1 1", state_out, cnt_en);
    end
    btn_pp = 1'b1;
    cyc();
    #2 C_clr = 1'b1;
    model_reset();
    #1;
    n_tests++;
    if ({state_out, cnt_en, clr_out, done, preset} !== {2'd0, 1'b0, 1'b1, 1'b0, 16'h0000}) begin
      n_fail++;
      $display("FAIL async_clr: got st=%0d en=%b clr=%b done=%b pre=%h want 0 0 1 0 0000",
               state_out, cnt_en, clr_out, done, preset);
    end
    @(posedge c_clk); @(posedge c_clk); #1;
    C_clr = 1'b0;
    for (int k = 1; k <= DB + 4; k++) begin
      cyc();
      n_tests++;
      if (state_out !== ((k >= DB + 4) ? 2'd1 : 2'd0)) begin
        n_fail++;
        $display("FAIL post_clr_press edge %0d: got state %0d want %0d", k, state_out, (k >= DB + 4) ? 1 : 0);
      end
    end
    btn_pp = 1'b0;
  endtask

  initial begin
    test_reset();
    test_press_latency();
    test_glitch();
    test_preset_freeze();
    test_done();
    test_simul_rst_pp();
    test_preset_terminal();
    test_random();
    test_clr_midrun();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
